// File: rtl/req_arbiter4.sv
// ---------------------------------------------------------------------------
// req_arbiter4
//
// Four-requester arbiter for a single shared downstream resource. On each
// arbitration the winner is picked either by fixed priority (req[3] highest)
// or round-robin (search starts after the previous owner), selected by
// rr_mode at the moment of arbitration. A grant is held until the owner
// asserts done, drops its request, or has held the resource for MAX_HOLD
// cycles. Every release is followed by one dead cycle (REL) with no grant,
// giving a break-before-make gap between owners.
//
// Parameters
//   MAX_HOLD  : maximum cycles a grant may be held (1..255)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   req[3:0]  in   request lines, req[i] = requester i wants the resource
//   rr_mode   in   0 = fixed priority (3 > 2 > 1 > 0), 1 = round-robin
//   done      in   current owner has finished, releases the grant
//   gnt[3:0]  out  registered one-hot grant, zero when no owner
//   gnt_id    out  registered encoded owner index, zero when no owner
//   gnt_valid out  registered, high while a grant is held (== |gnt)
//   timeout   out  registered one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module req_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rr_mode,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_REL   = 2'b10
    } state_t;

    // Hold counter value seen in the last permitted grant cycle.
    localparam logic [7:0] HOLD_LAST_C = 8'(MAX_HOLD - 1);

    // Highest set index wins; with no request the result is unused.
    function automatic logic [1:0] fixed_pick(input logic [3:0] r);
        logic [1:0] pick;
        casez (r)
            4'b1???: pick = 2'd3;
            4'b01??: pick = 2'd2;
            4'b001?: pick = 2'd1;
            4'b0001: pick = 2'd0;
            default: pick = 2'd0;
        endcase
        return pick;
    endfunction

    // First set request scanning upward from last+1, wrapping mod 4.
    // The 2-bit add wraps naturally; k = 4 revisits the previous owner last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx   = last + 2'(k);
            pick  = (!found && r[idx]) ? idx : pick;
            found = found | r[idx];
        end
        return pick;
    endfunction

    // Encoded index to one-hot select.
    function automatic logic [3:0] onehot4(input logic [1:0] id);
        logic [3:0] oh;
        case (id)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] hold_cnt_r;
    logic [7:0] hold_cnt_nxt_s;
    logic [1:0] last_id_r;
    logic [1:0] last_id_nxt_s;
    logic [3:0] gnt_r;
    logic [3:0] gnt_nxt_s;
    logic [1:0] gnt_id_r;
    logic [1:0] gnt_id_nxt_s;
    logic       gnt_valid_r;
    logic       gnt_valid_nxt_s;
    logic       timeout_r;
    logic       timeout_nxt_s;

    logic [1:0] winner_s;
    logic       owner_rel_s;
    logic       hold_exp_s;

    // Winner selection and release-cause decode.
    always_comb begin
        winner_s    = 2'd0;
        owner_rel_s = 1'b0;
        hold_exp_s  = 1'b0;
        if (rr_mode) begin
            winner_s = rr_pick(req, last_id_r);
        end else begin
            winner_s = fixed_pick(req);
        end
        // done and a request drop together count as a single release.
        owner_rel_s = done | ~req[gnt_id_r];
        hold_exp_s  = (hold_cnt_r == HOLD_LAST_C);
    end

    // Next-state and next-output logic; outputs are zero unless a grant is
    // being entered or continued.
    always_comb begin
        state_nxt_s     = state_r;
        hold_cnt_nxt_s  = 8'd0;
        last_id_nxt_s   = last_id_r;
        gnt_nxt_s       = 4'b0000;
        gnt_id_nxt_s    = 2'd0;
        gnt_valid_nxt_s = 1'b0;
        timeout_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt_s     = ST_GRANT;
                    last_id_nxt_s   = winner_s;
                    gnt_nxt_s       = onehot4(winner_s);
                    gnt_id_nxt_s    = winner_s;
                    gnt_valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (owner_rel_s) begin
                    state_nxt_s = ST_REL;
                end else if (hold_exp_s) begin
                    // Forced release only when no voluntary cause exists.
                    state_nxt_s   = ST_REL;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_GRANT;
                    hold_cnt_nxt_s  = hold_cnt_r + 8'd1;
                    gnt_nxt_s       = gnt_r;
                    gnt_id_nxt_s    = gnt_id_r;
                    gnt_valid_nxt_s = 1'b1;
                end
            end
            ST_REL: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with dominant synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= 8'd0;
            last_id_r   <= 2'd3;
            gnt_r       <= 4'b0000;
            gnt_id_r    <= 2'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            last_id_r   <= last_id_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_id_r    <= gnt_id_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_req_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_req_arbiter4
//
// Directed scenarios followed by a randomized run. Expected outputs come from
// a cycle-level reference model that tracks the current owner, how many
// cycles it has held the resource, whether a dead cycle is pending, and the
// previous owner for round-robin.
// ---------------------------------------------------------------------------
module tb_req_arbiter4;

    localparam int MAX_HOLD_TB = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rr_mode;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests;
    int fails;

    // Reference model state.
    int m_owner;   // -1 when nobody owns the resource
    int m_held;    // cycles the current owner has been visible
    int m_last;    // previous owner index
    bit m_rel;     // dead cycle in progress
    bit m_tmo;     // expected timeout output

    req_arbiter4 #(.MAX_HOLD(MAX_HOLD_TB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_mode   (rr_mode),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input bit rr, input int last);
        if (!rr) begin
            for (int i = 3; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (r[(last + k) % 4]) return (last + k) % 4;
            end
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] q, input logic m, input logic d);
        int w;
        if (r) begin
            m_owner = -1; m_held = 0; m_last = 3; m_rel = 0; m_tmo = 0;
        end else if (m_owner >= 0) begin
            m_tmo = 0;
            if (d || !q[m_owner]) begin
                m_owner = -1; m_rel = 1;
            end else if (m_held >= MAX_HOLD_TB) begin
                m_owner = -1; m_rel = 1; m_tmo = 1;
            end else begin
                m_held++;
            end
        end else if (m_rel) begin
            m_rel = 0; m_tmo = 0;
        end else begin
            m_tmo = 0;
            w = pick(q, m, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input logic r, input logic [3:0] q, input logic m, input logic d);
        logic [3:0] e_gnt;
        logic [1:0] e_id;
        rst = r; req = q; rr_mode = m; done = d;
        @(posedge clk);
        model_edge(r, q, m, d);
        #1;
        e_gnt = 4'b0000;
        e_id  = 2'd0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_id = 2'(m_owner);
        end
        check("gnt",       {4'b0000, gnt},       {4'b0000, e_gnt});
        check("gnt_id",    {6'b000000, gnt_id},  {6'b000000, e_id});
        check("gnt_valid", {7'b0000000, gnt_valid}, {7'b0000000, (m_owner >= 0) ? 1'b1 : 1'b0});
        check("timeout",   {7'b0000000, timeout},   {7'b0000000, m_tmo});
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] oh;
        tests = 0; fails = 0;
        m_owner = -1; m_held = 0; m_last = 3; m_rel = 0; m_tmo = 0;
        rst = 1'b1; req = 4'b0000; rr_mode = 1'b0; done = 1'b0;

        // Reset with all requests high, then release with no requests.
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        check("rst_gnt", {4'b0000, gnt}, 8'h00);
        check("rst_tmo", {7'b0000000, timeout}, 8'h00);
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        check("idle_gnt", {4'b0000, gnt}, 8'h00);

        // Fixed priority with req = 0110.
        step(1'b0, 4'b0110, 1'b0, 1'b0);
        check("fp_gnt", {4'b0000, gnt}, 8'h04);
        check("fp_id", {6'b000000, gnt_id}, 8'h02);
        step(1'b0, 4'b0110, 1'b0, 1'b1);
        check("fp_rel", {4'b0000, gnt}, 8'h00);
        step(1'b0, 4'b0110, 1'b0, 1'b0);
        check("fp_idle", {4'b0000, gnt}, 8'h00);
        step(1'b0, 4'b0110, 1'b0, 1'b0);
        check("fp_regnt", {4'b0000, gnt}, 8'h04);

        // Round-robin fairness from reset: order 0,1,2,3,0.
        step(1'b1, 4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0000;
            oh[k % 4] = 1'b1;
            step(1'b0, 4'b1111, 1'b1, 1'b0);
            check("rr_order", {4'b0000, gnt}, {4'b0000, oh});
            step(1'b0, 4'b1111, 1'b1, 1'b1);
            check("rr_gap", {4'b0000, gnt}, 8'h00);
            step(1'b0, 4'b1111, 1'b1, 1'b0);
        end

        // Timeout: req = 0001 held for exactly MAX_HOLD cycles.
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        check("to_gnt", {4'b0000, gnt}, 8'h01);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 4'b0001, 1'b0, 1'b0);
            check("to_hold", {4'b0000, gnt}, 8'h01);
            check("to_early", {7'b0000000, timeout}, 8'h00);
        end
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        check("to_drop", {4'b0000, gnt}, 8'h00);
        check("to_pulse", {7'b0000000, timeout}, 8'h01);
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        check("to_once", {7'b0000000, timeout}, 8'h00);
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        check("to_regnt", {4'b0000, gnt}, 8'h01);

        // Request drop with a late higher requester.
        step(1'b0, 4'b0010, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 1'b0, 1'b0);
        check("drop_own", {4'b0000, gnt}, 8'h02);
        step(1'b0, 4'b1010, 1'b0, 1'b0);
        check("no_preempt", {4'b0000, gnt}, 8'h02);
        step(1'b0, 4'b1000, 1'b0, 1'b0);
        check("drop_rel", {4'b0000, gnt}, 8'h00);
        step(1'b0, 4'b1000, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 1'b0, 1'b0);
        check("late_gnt", {4'b0000, gnt}, 8'h08);

        // Reset mid-grant, then round-robin restarts at index 0.
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        check("mid_gnt", {4'b0000, gnt}, 8'h04);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        check("mid_rst", {4'b0000, gnt}, 8'h00);
        step(1'b0, 4'b1111, 1'b1, 1'b0);
        check("post_rst", {4'b0000, gnt}, 8'h01);

        // Randomized traffic against the reference model.
        rq = 4'b1111;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                 rq,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
